audio_sample_buffer: RTL and testbench
======================================

// Module: audio_sample_buffer
// PURPOSE
//  Downstream of the microphone I2S receiver: takes each completed 36-bit stereo frame (sdata/sdone),
//  stores the left-channel sample in on-chip RAM during RECORD, then replays it through a PWM DAC
//  during PLAY. Sits between the mic receiver and the board audio-out pin.
// PARAMETERS
//  DEPTH     1024  samples stored; ADDR_W = $clog2(DEPTH)
//  SAMPLE_W  18    bits per stored sample (left channel = sdata[35:18])
//  PWM_W     8     PWM resolution; duty = top PWM_W bits of sample, MSB inverted (2's comp -> offset)
//  PLAY_DIV  2500  clk cycles per played sample (50 MHz / 2500 = 20 kHz)
// PORTS
//  clk      in   1         system clock
//  reset    in   1         synchronous, active-high reset
//  rec      in   1         start-record pulse (honoured only in IDLE)
//  play     in   1         start-playback pulse (honoured only in IDLE, count>0)
//  stop     in   1         abort RECORD/PLAY -> IDLE
//  sdata    in   36        mic frame {left[17:0],right[17:0]}; stable while sdone high
//  sdone    in   1         mic frame-complete level, mclk domain (async to clk)
//  state    out  2         0 IDLE, 1 RECORD, 2 PLAY
//  busy     out  1         state != IDLE
//  full     out  1         count == DEPTH
//  count    out  ADDR_W+1  samples currently stored
//  done     out  1         1-cycle pulse: record filled or playback finished
//  pwm_out  out  1         PWM audio output
// BEHAVIOUR
//  - Reset: state=IDLE, count=0, wr_ptr=0, rd_ptr=0, div=0, duty=2^(PWM_W-1), pwm_out=0, done=0, full=0.
//    Reset mid-RECORD/PLAY aborts immediately; RAM contents are not cleared but are unreachable (count=0).
//  - sdone goes through a 2-FF synchroniser + rising-edge detect -> strobe; strobe asserts 3 clk after
//    sdone rises; sdata sampled on the strobe cycle. One strobe per sdone high phase.
//  - IDLE: rec -> count=0, wr_ptr=0, full=0, state RECORD. play with count>0 -> rd_ptr=0, div=0, PLAY.
//    play with count==0 ignored. rec and play together -> rec wins. stop is a no-op.
//  - RECORD: each strobe writes mem[wr_ptr]=sdata[35:18], wr_ptr++, count++. The write making count==DEPTH
//    sets full=1, pulses done, returns to IDLE. Strobes in IDLE/PLAY are dropped.
//  - PLAY: div counts 0..PLAY_DIV-1; at terminal, read mem[rd_ptr] (1-cycle registered read); duty is updated
//    the next cycle; rd_ptr++. After the sample at rd_ptr==count-1 has completed its PLAY_DIV period:
//    IDLE, pulse done, duty=midscale. count is preserved, so play repeats the take.
//  - Priority each cycle: reset > stop > rec > play > strobe. stop together with strobe drops the sample.
//    stop during PLAY forces duty to midscale on the next cycle; no done pulse.
//  - PWM: free-running PWM_W counter pc; pwm_out <= (pc < duty), registered. Duty 0 -> always 0;
//    duty 2^PWM_W-1 -> high for all but one cycle per period. Midscale in IDLE/RECORD (no pop).
//  - All counters wrap modulo their width; ptr wrap at DEPTH is legal only under LOOP_PLAY_EN.
// CONFIGURATION
//  LOOP_PLAY_EN defined: at the end of a take, rd_ptr wraps to 0 and PLAY continues indefinitely, with no done
//    pulse; the only exits are stop and reset.
//  LOOP_PLAY_EN undefined: single-shot playback as above.
// STRUCTURE
//  audio_pkg: state encodings (ST_IDLE/ST_RECORD/ST_PLAY), L_CH_HI=35/L_CH_LO=18, and a midscale-duty
//    helper constant.
//  Sub-module pwm_dac (PWM_W): clk, reset, duty[PWM_W-1:0] -> pwm_out. Synchroniser, FSM and RAM stay here.
// TESTING (DEPTH=8, PLAY_DIV=10, PWM_W=8 overrides)
//  1 reset, rec, 4 sdone pulses with left=18'h00001..4 -> count=4, state=RECORD; stop -> IDLE, count=4.
//  2 rec, 9 sdone pulses -> full=1 and a single done pulse after the 8th pulse; 9th ignored, count=8.
//  3 store {18'h1FFFF,18'h20000}, play -> duty 0xFF then 0x00, each held 10 clk; IDLE + done after 20 clk.
//  4 play with count=0 -> state stays IDLE, pwm at midscale (128/256 high).
//  5 during PLAY assert stop+rec same cycle -> IDLE, count unchanged, no done pulse.
//  6 LOOP_PLAY_EN: 2-sample take loops past 20 clk with no done pulse, duty sequence repeats; stop -> IDLE.

Source files
------------

// File: rtl/audio_pkg.sv
// ============================================================================
// Module : audio_pkg
// Brief  : Shared state encodings, left-channel slice bounds and the
//          midscale-duty helper for the audio sample buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_t;

    localparam int L_CH_HI = 35;
    localparam int L_CH_LO = 18;

    // Offset-binary zero: the duty that produces a 50% square wave (silence).
    function automatic logic [31:0] midscale_duty(input int pwm_w);
        return 32'd1 << (pwm_w - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_dac.sv
// ============================================================================
// Module : pwm_dac
// Brief  : Free-running PWM_W-bit counter; output high while counter < duty.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_dac #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm_out
);

    logic [PWM_W-1:0] r_pc;
    logic             r_pwm;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_pc  <= r_pc + 1'b1;
            r_pwm <= (r_pc < duty);
        end
    end

    assign pwm_out = r_pwm;

endmodule

`default_nettype wire

// File: rtl/audio_sample_buffer.sv
// ============================================================================
// Module : audio_sample_buffer
// Brief  : Records left-channel mic samples into RAM and replays them through
//          a PWM DAC. Optional macro LOOP_PLAY_EN makes playback loop forever.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module audio_sample_buffer
    import audio_pkg::*;
#(
    parameter int  DEPTH    = 1024,
    parameter int  SAMPLE_W = 18,
    parameter int  PWM_W    = 8,
    parameter int  PLAY_DIV = 2500,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rec,
    input  logic            play,
    input  logic            stop,
    input  logic [35:0]     sdata,
    input  logic            sdone,
    output logic [1:0]      state,
    output logic            busy,
    output logic            full,
    output logic [ADDR_W:0] count,
    output logic            done,
    output logic            pwm_out
);

    localparam int               DIV_W      = $clog2(PLAY_DIV);
    localparam logic [PWM_W-1:0] C_MIDSCALE = PWM_W'(midscale_duty(PWM_W));
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(PLAY_DIV - 1);
    localparam logic [ADDR_W:0]  C_FULL     = (ADDR_W + 1)'(DEPTH);

    state_t              r_state;
    logic [SAMPLE_W-1:0] r_mem [DEPTH];
    logic [SAMPLE_W-1:0] r_rd_data;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic [DIV_W-1:0]    r_div;
    logic [PWM_W-1:0]    r_duty;
    logic                r_done;
    logic                r_sync1, r_sync2, r_sync3, r_strobe;

    logic [ADDR_W-1:0]   w_raddr;
    logic [PWM_W-1:0]    w_rd_duty;
    logic                w_last;
    logic                w_we;
    logic                w_unused;

    // sdone is asynchronous: two flops to resolve metastability, a third for edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync3  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_sync1  <= sdone;
            r_sync2  <= r_sync1;
            r_sync3  <= r_sync2;
            r_strobe <= r_sync2 & ~r_sync3;
        end
    end

    assign w_last = ({1'b0, r_rd_ptr} == r_count - 1'b1);
    assign w_we   = (r_state == ST_RECORD) && r_strobe && !stop && !reset;

    // Prefetch the sample that plays next so it is ready at the period boundary;
    // outside PLAY (or when leaving it) the address parks on sample 0 for the next start.
    assign w_raddr = (r_state == ST_PLAY && !stop && !w_last) ? r_rd_ptr + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= sdata[L_CH_HI:L_CH_LO];
        end
        r_rd_data <= r_mem[w_raddr];
    end

    // Two's complement to offset binary: invert the sign bit of the top PWM_W bits.
    assign w_rd_duty = {~r_rd_data[SAMPLE_W-1], r_rd_data[SAMPLE_W-2 -: PWM_W-1]};
    assign w_unused  = ^{sdata[L_CH_LO-1:0], r_rd_data[SAMPLE_W-PWM_W-1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_div    <= '0;
            r_duty   <= C_MIDSCALE;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (stop) begin
                if (r_state != ST_IDLE) begin
                    r_state <= ST_IDLE;
                    r_duty  <= C_MIDSCALE;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (rec) begin
                            r_count  <= '0;
                            r_wr_ptr <= '0;
                            r_state  <= ST_RECORD;
                        end else if (play && r_count != '0) begin
                            r_rd_ptr <= '0;
                            r_div    <= '0;
                            r_duty   <= w_rd_duty;
                            r_state  <= ST_PLAY;
                        end
                    end
                    ST_RECORD: begin
                        if (r_strobe) begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            r_count  <= r_count + 1'b1;
                            if (r_count == C_FULL - 1'b1) begin
                                r_done  <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    ST_PLAY: begin
                        if (r_div == C_DIV_LAST) begin
                            r_div <= '0;
                            if (w_last) begin
`ifdef LOOP_PLAY_EN
                                r_rd_ptr <= '0;
                                r_duty   <= w_rd_duty;
`else
                                r_state  <= ST_IDLE;
                                r_done   <= 1'b1;
                                r_duty   <= C_MIDSCALE;
`endif
                            end else begin
                                r_rd_ptr <= r_rd_ptr + 1'b1;
                                r_duty   <= w_rd_duty;
                            end
                        end else begin
                            r_div <= r_div + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    pwm_dac #(
        .PWM_W (PWM_W)
    ) u_pwm_dac (
        .clk     (clk),
        .reset   (reset),
        .duty    (r_duty),
        .pwm_out (pwm_out)
    );

    assign state = r_state;
    assign busy  = (r_state != ST_IDLE);
    assign full  = (r_count == C_FULL);
    assign count = r_count;
    assign done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_audio_sample_buffer.sv
// ============================================================================
// Module : tb_audio_sample_buffer
// Brief  : Directed + randomized bench for audio_sample_buffer against a
//          time-based behavioural model (DEPTH=8, PLAY_DIV=10, PWM_W=8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_audio_sample_buffer;

    localparam int DEPTH    = 8;
    localparam int PLAY_DIV = 10;
    localparam int PWM_W    = 8;
    localparam int MID      = 128;

    logic        clk = 1'b0;
    logic        reset, rec, play, stop, sdone;
    logic [35:0] sdata;
    logic [1:0]  state;
    logic        busy, full, done, pwm_out;
    logic [3:0]  count;

    always #5 clk = ~clk;

    audio_sample_buffer #(
        .DEPTH    (DEPTH),
        .SAMPLE_W (18),
        .PWM_W    (PWM_W),
        .PLAY_DIV (PLAY_DIV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rec     (rec),
        .play    (play),
        .stop    (stop),
        .sdata   (sdata),
        .sdone   (sdone),
        .state   (state),
        .busy    (busy),
        .full    (full),
        .count   (count),
        .done    (done),
        .pwm_out (pwm_out)
    );

    int n_cmp  = 0;
    int n_err  = 0;
    int n_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_state = 0, m_count = 0, m_done = 0, m_duty = MID, m_pwm = 0, m_pc = 0, m_t = 0, m_k = 0;
    int m_mem [DEPTH];
    bit hs [4];
    bit m_valid = 0;
    bit m_strobe;

    function automatic int duty_of(input int s);
        return ((s >> 10) + 128) % 256;
    endfunction

    always @(posedge clk) begin
        m_strobe = hs[2] & ~hs[3];   // frame strobe lands 3 clk after sdone is first seen
        if (reset) begin
            m_pc = 0; m_pwm = 0;
        end else begin
            m_pwm = (m_pc < m_duty) ? 1 : 0;
            m_pc  = (m_pc + 1) % 256;
        end
        m_done = 0;
        if (reset) begin
            m_state = 0; m_count = 0; m_duty = MID; m_valid = 1;
            hs[0] = 0; hs[1] = 0; hs[2] = 0; hs[3] = 0;
        end else begin
            hs[3] = hs[2]; hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = sdone;
            if (stop) begin
                if (m_state != 0) begin m_state = 0; m_duty = MID; end
            end else if (m_state == 0) begin
                if (rec) begin
                    m_count = 0; m_state = 1;
                end else if (play && m_count > 0) begin
                    m_state = 2; m_t = 0; m_duty = duty_of(m_mem[0]);
                end
            end else if (m_state == 1) begin
                if (m_strobe) begin
                    m_mem[m_count] = int'(sdata[35:18]);
                    m_count++;
                    if (m_count == DEPTH) begin m_state = 0; m_done = 1; end
                end
            end else begin
                m_t++;
                if (m_t % PLAY_DIV == 0) begin
                    m_k = m_t / PLAY_DIV;
                    if (m_k >= m_count) begin
`ifdef LOOP_PLAY_EN
                        m_t = 0; m_duty = duty_of(m_mem[0]);
`else
                        m_state = 0; m_done = 1; m_duty = MID;
`endif
                    end else begin
                        m_duty = duty_of(m_mem[m_k]);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("state", 32'(state), m_state);
            chk("busy",  32'(busy),  (m_state != 0) ? 1 : 0);
            chk("full",  32'(full),  (m_count == DEPTH) ? 1 : 0);
            chk("count", 32'(count), m_count);
            chk("done",  32'(done),  m_done);
            chk("pwm",   32'(pwm_out), m_pwm);
        end
        if (done === 1'b1) n_done++;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int which);
        if (which == 0) rec = 1'b1;
        else if (which == 1) play = 1'b1;
        else stop = 1'b1;
        tick(1);
        rec = 1'b0; play = 1'b0; stop = 1'b0;
    endtask

    task automatic frame(input logic [17:0] left, input int stop_at, input int gap);
        sdata = {left, 18'($urandom)};
        sdone = 1'b1;
        for (int i = 0; i < 6; i++) begin
            stop = (i == stop_at);
            tick(1);
        end
        stop  = 1'b0;
        sdone = 1'b0;
        tick(gap);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, c, hi1, hi2, nfr;
        reset = 1'b1; rec = 1'b0; play = 1'b0; stop = 1'b0; sdone = 1'b0; sdata = '0;
        tick(3);
        reset = 1'b0;
        chk("reset_state", 32'(state), 0);
        chk("reset_count", 32'(count), 0);
        chk("reset_full",  32'(full),  0);
        chk("reset_pwm",   32'(pwm_out), 0);

        // 1: record four frames, stop
        pulse(0);
        for (int i = 1; i <= 4; i++) frame(18'(i), -1, 3);
        chk("t1_count", 32'(count), 4);
        chk("t1_state", 32'(state), 1);
        pulse(2);
        chk("t1_stop_state", 32'(state), 0);
        chk("t1_stop_count", 32'(count), 4);

        // 2: overfill; one done pulse, ninth frame dropped
        d0 = n_done;
        pulse(0);
        for (int i = 0; i < 9; i++) frame(18'($urandom), -1, 2);
        chk("t2_done_pulses", n_done - d0, 1);
        chk("t2_full",  32'(full),  1);
        chk("t2_count", 32'(count), 8);

        // 3/6: two-sample take at extreme duties
        pulse(0);
        frame(18'h1FFFF, -1, 2);
        frame(18'h20000, -1, 2);
        pulse(2);
        d0 = n_done;
        play = 1'b1; tick(1); play = 1'b0;
        hi1 = 0; hi2 = 0; c = 1;
`ifdef LOOP_PLAY_EN
        for (int i = 0; i < 40; i++) begin
            tick(1); c++;
            if ((c >= 22 && c <= 31) || (c >= 2 && c <= 11)) hi1 += int'(pwm_out);
            else if ((c >= 12 && c <= 21) || (c >= 32 && c <= 41)) hi2 += int'(pwm_out);
        end
        chk("t6_no_done",  n_done - d0, 0);
        chk("t6_state",    32'(state), 2);
        chk("t6_high_ff",  (hi1 >= 18) ? 1 : 0, 1);
        chk("t6_high_00",  hi2, 0);
        pulse(2);
        chk("t6_stop_state", 32'(state), 0);
`else
        while (done !== 1'b1 && c < 60) begin
            tick(1); c++;
            if (c <= 11) hi1 += int'(pwm_out);
            else hi2 += int'(pwm_out);
        end
        chk("t3_play_len", c - 1, 20);
        chk("t3_high_ff",  (hi1 >= 9) ? 1 : 0, 1);
        chk("t3_high_00",  hi2, 0);
        tick(1);
        chk("t3_state", 32'(state), 0);
        chk("t3_count", 32'(count), 2);
`endif

        // 4: play with empty take is ignored, output at midscale
        pulse(0);
        pulse(2);
        pulse(1);
        chk("t4_state", 32'(state), 0);
        hi1 = 0;
        for (int i = 0; i < 256; i++) begin tick(1); hi1 += int'(pwm_out); end
        chk("t4_mid_highs", hi1, 128);

        // 5: stop+rec during PLAY
        pulse(0);
        for (int i = 0; i < 3; i++) frame(18'($urandom), -1, 2);
        pulse(2);
        pulse(1);
        tick(5);
        d0 = n_done;
        stop = 1'b1; rec = 1'b1; tick(1); stop = 1'b0; rec = 1'b0;
        tick(30);
        chk("t5_state", 32'(state), 0);
        chk("t5_count", 32'(count), 3);
        chk("t5_no_done", n_done - d0, 0);

        // randomized sessions
        for (int it = 0; it < 25; it++) begin
            pulse(0);
            nfr = $urandom_range(0, 10);
            for (int f = 0; f < nfr; f++)
                frame(18'($urandom), ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1,
                      $urandom_range(0, 4));
            if ($urandom_range(0, 1) == 1) pulse(2);
            tick($urandom_range(0, 3));
            pulse(1);
            tick($urandom_range(0, 90));
            if ($urandom_range(0, 3) == 0) pulse($urandom_range(0, 1));
            pulse(2);
            tick($urandom_range(0, 3));
        end

        tick(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
